// File: rtl/spi_adc_pkg.sv
// Shared FSM encoding and parameter limits for the SPI ADC reader.
package spi_adc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_SHIFT = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   localparam int HALF_DIV_MIN   = 2;
   localparam int HALF_DIV_MAX   = 255;
   localparam int FRAME_BITS_MIN = 2;
   localparam int FRAME_BITS_MAX = 32;
   localparam int QUIET_MIN      = 1;
   localparam int QUIET_MAX      = 255;

   // Out-of-range parameters are pulled to the nearest legal value.
   function automatic int clamp(input int v, input int lo, input int hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period divider: emits fall/rise strobes at the end of each half period.
module spi_clk_div #(
   parameter int HALF_DIV = 13
) (
   input  logic clk,
   input  logic n_rst,
   input  logic en,
   output logic rise,
   output logic fall
);

   localparam int CW = $clog2(HALF_DIV + 1);

   logic [CW-1:0] cnt;
   logic          phase;
   logic          tick;

   // phase mirrors the sclk level of the half period in progress; a frame opens high.
   assign tick = en && (cnt == CW'(HALF_DIV - 1));
   assign rise = tick && !phase;
   assign fall = tick && phase;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt   <= '0;
         phase <= 1'b1;
      end else if (!en) begin
         cnt   <= '0;
         phase <= 1'b1;
      end else if (tick) begin
         cnt   <= '0;
         phase <= ~phase;
      end else begin
         cnt   <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/spi_adc_reader.sv
// SPI ADC frame reader: one conversion per start, or back-to-back frames while cont is high.
module spi_adc_reader
   import spi_adc_pkg::*;
#(
   parameter int HALF_DIV   = 13,
   parameter int FRAME_BITS = 16,
   parameter int LEAD_BITS  = 3,
   parameter int DATA_BITS  = 8,
   parameter int QUIET_CYC  = 4
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 start,
   input  logic                 cont,
   input  logic                 sdata,
   output logic                 cs_n,
   output logic                 sclk,
   output logic [DATA_BITS-1:0] adc_data,
   output logic                 data_valid,
   output logic                 busy
);

   localparam int HD = clamp(HALF_DIV, HALF_DIV_MIN, HALF_DIV_MAX);
   localparam int FB = clamp(FRAME_BITS, FRAME_BITS_MIN, FRAME_BITS_MAX);
   localparam int QC = clamp(QUIET_CYC, QUIET_MIN, QUIET_MAX);
   localparam int BW = $clog2(FB + 1);
   localparam int QW = $clog2(QUIET_MAX + 1);

   state_t               state;
   logic [BW-1:0]        bit_cnt;
   logic [QW-1:0]        q_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 div_en;
   logic                 rise;
   logic                 fall;
   logic                 in_data;

   assign div_en  = (state == ST_SETUP) || (state == ST_SHIFT);
   assign in_data = (bit_cnt > BW'(LEAD_BITS)) && (bit_cnt <= BW'(LEAD_BITS + DATA_BITS));

   spi_clk_div #(.HALF_DIV(HD)) u_div (
      .clk   (clk),
      .n_rst (n_rst),
      .en    (div_en),
      .rise  (rise),
      .fall  (fall)
   );

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state      <= ST_IDLE;
         cs_n       <= 1'b1;
         sclk       <= 1'b1;
         adc_data   <= '0;
         data_valid <= 1'b0;
         busy       <= 1'b0;
         bit_cnt    <= '0;
         q_cnt      <= '0;
         shreg      <= '0;
      end else begin
         data_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start || cont) begin
                  state <= ST_SETUP;
                  cs_n  <= 1'b0;
                  busy  <= 1'b1;
               end
            end
            ST_SETUP: begin
               if (fall) begin
                  state   <= ST_SHIFT;
                  sclk    <= 1'b0;
                  bit_cnt <= BW'(1);
               end
            end
            ST_SHIFT: begin
               if (rise) begin
                  sclk <= 1'b1;
                  if (in_data) shreg <= (shreg << 1) | DATA_BITS'(sdata);
               end else if (fall) begin
                  // The last bit's high phase ends the frame without another low phase.
                  if (bit_cnt == BW'(FB)) begin
                     state      <= ST_HOLD;
                     cs_n       <= 1'b1;
                     adc_data   <= shreg;
                     data_valid <= 1'b1;
                     bit_cnt    <= '0;
                     q_cnt      <= '0;
                  end else begin
                     sclk    <= 1'b0;
                     bit_cnt <= bit_cnt + BW'(1);
                  end
               end
            end
            ST_HOLD: begin
               if (q_cnt == QW'(QC - 1)) begin
                  q_cnt <= '0;
                  if (cont) begin
                     state <= ST_SETUP;
                     cs_n  <= 1'b0;
                  end else begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  q_cnt <= q_cnt + QW'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_adc_reader.sv
// Directed bench for spi_adc_reader: default instance plus a fast 12-bit instance.
module tb_spi_adc_reader;

   logic        clk = 1'b0;
   logic        n_rst = 1'b1;
   logic        start_a = 1'b0, cont_a = 1'b0, sdata_a = 1'b0;
   logic        cs_n_a, sclk_a, dv_a, busy_a;
   logic [7:0]  adc_a;
   logic        start_b = 1'b0, cont_b = 1'b0, sdata_b = 1'b0;
   logic        cs_n_b, sclk_b, dv_b, busy_b;
   logic [11:0] adc_b;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   spi_adc_reader dut_a (
      .clk(clk), .n_rst(n_rst), .start(start_a), .cont(cont_a), .sdata(sdata_a),
      .cs_n(cs_n_a), .sclk(sclk_a), .adc_data(adc_a), .data_valid(dv_a), .busy(busy_a)
   );

   spi_adc_reader #(.HALF_DIV(2), .FRAME_BITS(16), .LEAD_BITS(4), .DATA_BITS(12)) dut_b (
      .clk(clk), .n_rst(n_rst), .start(start_b), .cont(cont_b), .sdata(sdata_b),
      .cs_n(cs_n_b), .sclk(sclk_b), .adc_data(adc_b), .data_valid(dv_b), .busy(busy_b)
   );

   // ADC models: a frame word is loaded as cs_n falls, each sclk fall presents the next bit MSB first.
   logic [15:0] q_a[$];
   logic [15:0] q_b[$];
   logic [15:0] word_a = '0, word_b = '0;
   int          idx_a = 0, idx_b = 0;

   always @(negedge cs_n_a or negedge sclk_a) begin
      if (sclk_a) begin
         if (q_a.size() > 0) word_a = q_a.pop_front();
         idx_a = 0;
      end else if (!cs_n_a && idx_a < 16) begin
         idx_a++;
         sdata_a = word_a[16-idx_a];
      end
   end

   always @(negedge cs_n_b or negedge sclk_b) begin
      if (sclk_b) begin
         if (q_b.size() > 0) word_b = q_b.pop_front();
         idx_b = 0;
      end else if (!cs_n_b && idx_b < 16) begin
         idx_b++;
         sdata_b = word_b[16-idx_b];
      end
   end

   int   dv_a_cnt = 0, rise_a_cnt = 0, dv_b_cnt = 0;
   logic sclk_a_prev = 1'b1;

   always @(posedge clk) begin
      if (dv_a === 1'b1) dv_a_cnt++;
      if (dv_b === 1'b1) dv_b_cnt++;
      if (sclk_a === 1'b1 && sclk_a_prev === 1'b0 && cs_n_a === 1'b0) rise_a_cnt++;
      sclk_a_prev = sclk_a;
   end

   // Pulse start and count edges, the sampling edge being 1, until data_valid is seen.
   task automatic run_a(output int lat);
      lat = -1;
      @(negedge clk) start_a = 1'b1;
      for (int c = 1; c <= 3000; c++) begin
         @(posedge clk); #1;
         if (c == 1) start_a = 1'b0;
         if (dv_a === 1'b1) begin lat = c; break; end
      end
   endtask

   task automatic idle_wait_a(output int n);
      n = -1;
      for (int c = 1; c <= 3000; c++) begin
         @(posedge clk); #1;
         if (busy_a === 1'b0) begin n = c; break; end
      end
   endtask

   task automatic test_reset;
      #2 n_rst = 1'b0;
      #21;
      checks += 6;
      if (cs_n_a !== 1'b1) begin errors++; $display("FAIL reset_cs_n got=%b exp=1", cs_n_a); end
      if (sclk_a !== 1'b1) begin errors++; $display("FAIL reset_sclk got=%b exp=1", sclk_a); end
      if (adc_a !== 8'h00) begin errors++; $display("FAIL reset_adc got=%h exp=00", adc_a); end
      if (dv_a !== 1'b0)   begin errors++; $display("FAIL reset_dv got=%b exp=0", dv_a); end
      if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
      if (adc_b !== 12'h000) begin errors++; $display("FAIL reset_adc_b got=%h exp=000", adc_b); end
      @(negedge clk) n_rst = 1'b1;
      repeat (40) @(negedge clk);
      checks += 3;
      if (cs_n_a !== 1'b1) begin errors++; $display("FAIL post_reset_cs_n got=%b exp=1", cs_n_a); end
      if (busy_a !== 1'b0) begin errors++; $display("FAIL post_reset_busy got=%b exp=0", busy_a); end
      if (rise_a_cnt !== 0) begin errors++; $display("FAIL post_reset_sclk_rises got=%0d exp=0", rise_a_cnt); end
   endtask

   task automatic test_single;
      int lat, n, d0, r0;
      d0 = dv_a_cnt; r0 = rise_a_cnt;
      q_a.push_back(16'h14A0);
      run_a(lat);
      checks += 2;
      if (lat !== 430) begin errors++; $display("FAIL single_latency got=%0d exp=430", lat); end
      if (adc_a !== 8'hA5) begin errors++; $display("FAIL single_data got=%h exp=a5", adc_a); end
      idle_wait_a(n);
      repeat (20) @(negedge clk);
      checks += 3;
      if (n !== 4) begin errors++; $display("FAIL single_hold_len got=%0d exp=4", n); end
      if (dv_a_cnt - d0 !== 1) begin errors++; $display("FAIL single_dv_pulses got=%0d exp=1", dv_a_cnt - d0); end
      if (rise_a_cnt - r0 !== 16) begin errors++; $display("FAIL single_sclk_rises got=%0d exp=16", rise_a_cnt - r0); end
   endtask

   task automatic test_discard;
      int lat, n;
      q_a.push_back(16'hA795);
      run_a(lat);
      idle_wait_a(n);
      checks++;
      if (adc_a !== 8'h3C) begin errors++; $display("FAIL discard_toggle got=%h exp=3c", adc_a); end
      q_a.push_back(16'hE01F);
      run_a(lat);
      idle_wait_a(n);
      checks++;
      if (adc_a !== 8'h00) begin errors++; $display("FAIL discard_ones got=%h exp=00", adc_a); end
   endtask

   task automatic test_cont;
      logic [7:0] exp_d[3] = '{8'h11, 8'h22, 8'h33};
      int d0, r0, n, hi;
      bit seen;
      d0 = dv_a_cnt; r0 = rise_a_cnt;
      q_a.push_back(16'h0220); q_a.push_back(16'h0440); q_a.push_back(16'h0660);
      @(negedge clk) cont_a = 1'b1;
      for (int f = 0; f < 3; f++) begin
         seen = 1'b0;
         for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (dv_a === 1'b1) begin seen = 1'b1; break; end
         end
         checks++;
         if (!seen) begin errors++; $display("FAIL cont_dv_%0d got=timeout exp=pulse", f); end
         else if (adc_a !== exp_d[f]) begin errors++; $display("FAIL cont_data_%0d got=%h exp=%h", f, adc_a, exp_d[f]); end
         if (f < 2) begin
            hi = 1;
            for (int c = 0; c < 100; c++) begin
               @(posedge clk); #1;
               if (cs_n_a === 1'b1) hi++; else break;
            end
            checks++;
            if (hi !== 4) begin errors++; $display("FAIL cont_gap_%0d got=%0d exp=4", f, hi); end
            if (f == 1) cont_a = 1'b0;
         end
      end
      idle_wait_a(n);
      repeat (20) @(negedge clk);
      checks += 4;
      if (dv_a_cnt - d0 !== 3) begin errors++; $display("FAIL cont_dv_pulses got=%0d exp=3", dv_a_cnt - d0); end
      if (rise_a_cnt - r0 !== 48) begin errors++; $display("FAIL cont_sclk_rises got=%0d exp=48", rise_a_cnt - r0); end
      if (adc_a !== 8'h33) begin errors++; $display("FAIL cont_final_data got=%h exp=33", adc_a); end
      if (busy_a !== 1'b0) begin errors++; $display("FAIL cont_final_busy got=%b exp=0", busy_a); end
   endtask

   task automatic test_start_held;
      int d0, r0, n, drops, c;
      d0 = dv_a_cnt; r0 = rise_a_cnt; drops = 0;
      q_a.push_back(16'h0B40);
      @(negedge clk) start_a = 1'b1;
      for (c = 1; c <= 3000; c++) begin
         @(posedge clk); #1;
         if (c == 150) start_a = 1'b0;
         if (c == 152) start_a = 1'b1;
         if (c == 300) start_a = 1'b0;
         if (busy_a !== 1'b1) drops++;
         if (dv_a === 1'b1) break;
      end
      idle_wait_a(n);
      repeat (600) @(negedge clk);
      checks += 5;
      if (drops !== 0) begin errors++; $display("FAIL held_busy_drops got=%0d exp=0", drops); end
      if (n !== 4) begin errors++; $display("FAIL held_hold_len got=%0d exp=4", n); end
      if (dv_a_cnt - d0 !== 1) begin errors++; $display("FAIL held_dv_pulses got=%0d exp=1", dv_a_cnt - d0); end
      if (rise_a_cnt - r0 !== 16) begin errors++; $display("FAIL held_sclk_rises got=%0d exp=16", rise_a_cnt - r0); end
      if (adc_a !== 8'h5A) begin errors++; $display("FAIL held_data got=%h exp=5a", adc_a); end
   endtask

   task automatic test_reset_mid;
      int r0, d0;
      bit ok;
      r0 = rise_a_cnt; ok = 1'b0;
      q_a.push_back(16'h1860);
      @(negedge clk) start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         if (rise_a_cnt - r0 >= 5 && sclk_a === 1'b0) begin ok = 1'b1; break; end
      end
      #2 n_rst = 1'b0;
      #1;
      checks += 6;
      if (!ok) begin errors++; $display("FAIL abort_reach_bit6 got=timeout exp=bit6"); end
      if (cs_n_a !== 1'b1) begin errors++; $display("FAIL abort_cs_n got=%b exp=1", cs_n_a); end
      if (sclk_a !== 1'b1) begin errors++; $display("FAIL abort_sclk got=%b exp=1", sclk_a); end
      if (adc_a !== 8'h00) begin errors++; $display("FAIL abort_adc got=%h exp=00", adc_a); end
      if (busy_a !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy_a); end
      if (dv_a !== 1'b0) begin errors++; $display("FAIL abort_dv got=%b exp=0", dv_a); end
      @(negedge clk) n_rst = 1'b1;
      d0 = dv_a_cnt; r0 = rise_a_cnt;
      repeat (1000) @(negedge clk);
      checks += 3;
      if (dv_a_cnt - d0 !== 0) begin errors++; $display("FAIL abort_no_dv got=%0d exp=0", dv_a_cnt - d0); end
      if (rise_a_cnt - r0 !== 0) begin errors++; $display("FAIL abort_no_sclk got=%0d exp=0", rise_a_cnt - r0); end
      if (adc_a !== 8'h00) begin errors++; $display("FAIL abort_adc_held got=%h exp=00", adc_a); end
   endtask

   task automatic test_params;
      int lat, d0;
      d0 = dv_b_cnt; lat = -1;
      q_b.push_back(16'h5ABC);
      @(negedge clk) start_b = 1'b1;
      for (int c = 1; c <= 1000; c++) begin
         @(posedge clk); #1;
         if (c == 1) start_b = 1'b0;
         if (dv_b === 1'b1) begin lat = c; break; end
      end
      repeat (20) @(negedge clk);
      checks += 3;
      if (lat !== 67) begin errors++; $display("FAIL params_latency got=%0d exp=67", lat); end
      if (adc_b !== 12'hABC) begin errors++; $display("FAIL params_data got=%h exp=abc", adc_b); end
      if (dv_b_cnt - d0 !== 1) begin errors++; $display("FAIL params_dv_pulses got=%0d exp=1", dv_b_cnt - d0); end
   endtask

   initial begin
      test_reset;
      test_single;
      test_discard;
      test_cont;
      test_start_held;
      test_reset_mid;
      test_params;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
